// File: rtl/wfg_wb_demux.sv
// Wishbone page demultiplexer: one master, NSLV slave pages selected by the
// address bits above PAGE_LSB, with a per-access ack timeout and an error counter.
module wfg_wb_demux #(
    parameter int BUSW     = 32,
    parameter int NSLV     = 6,
    parameter int PAGE_LSB = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                 io_wbs_clk,
    input  logic                 io_wbs_rst,
    input  logic [BUSW-1:0]      io_wbs_adr,
    input  logic [BUSW-1:0]      io_wbs_datwr,
    input  logic                 io_wbs_we,
    input  logic                 io_wbs_stb,
    input  logic                 io_wbs_cyc,
    output logic [BUSW-1:0]      io_wbs_datrd,
    output logic                 io_wbs_ack,
    output logic                 io_wbs_err,
    output logic [NSLV-1:0]      slv_stb_o,
    output logic                 slv_cyc_o,
    output logic                 slv_we_o,
    output logic [PAGE_LSB-1:0]  slv_adr_o,
    output logic [BUSW-1:0]      slv_dat_o,
    input  logic [NSLV-1:0]      slv_ack_i,
    input  logic [NSLV*BUSW-1:0] slv_dat_i,
    output logic                 busy_o,
    output logic [7:0]           err_cnt_o,
    output logic [1:0]           o_dbg_state
);

    localparam int PW = BUSW - PAGE_LSB;
    localparam int CW = $clog2(TIMEOUT + 1);

    // Handshake: the master request is taken when stb and cyc are both high in
    // IDLE; the response is a single-cycle ack or err pulse in RESP.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_RESP = 2'd2} state_t;

    state_t               r_state, w_next;
    logic [3:0]           r_sel;
    logic [PAGE_LSB-1:0]  r_off;
    logic                 r_we;
    logic [BUSW-1:0]      r_wdat;
    logic [BUSW-1:0]      r_rdata;
    logic                 r_err;
    logic [CW-1:0]        r_cnt;
    logic [7:0]           r_err_cnt;

    logic [PW-1:0]        w_page;
    logic                 w_mapped;
    logic [3:0]           w_idx;
    logic                 w_ack_sel;
    logic [BUSW-1:0]      w_dat_sel;
    logic                 w_start;
    logic                 w_ack_take;
    logic                 w_err_entry;
    logic                 w_active;
    logic                 w_resp;

    assign w_page   = io_wbs_adr[BUSW-1:PAGE_LSB];
    assign w_mapped = (w_page != '0) && (w_page <= PW'(NSLV));
    assign w_idx    = 4'(w_page - PW'(1));
    assign w_active = (r_state == S_ACTIVE);
    assign w_resp   = (r_state == S_RESP);

    // Only the latched slave's ack and data are visible; the rest are ignored.
    always_comb begin
        w_ack_sel = 1'b0;
        w_dat_sel = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (r_sel == 4'(k)) begin
                w_ack_sel = slv_ack_i[k];
                w_dat_sel = slv_dat_i[k*BUSW +: BUSW];
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_ack_take  = 1'b0;
        w_err_entry = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_wbs_stb && io_wbs_cyc) begin
                    w_start = 1'b1;
                    if (w_mapped) begin
                        w_next = S_ACTIVE;
                    end else begin
                        w_next      = S_RESP;
                        w_err_entry = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                // A dropped cycle abandons the access silently, even if an ack arrives.
                if (!io_wbs_cyc) begin
                    w_next = S_IDLE;
                end else if (w_ack_sel) begin
                    w_next     = S_RESP;
                    w_ack_take = 1'b1;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_next      = S_RESP;
                    w_err_entry = 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_off     <= '0;
            r_we      <= 1'b0;
            r_wdat    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_sel  <= w_mapped ? w_idx : 4'd0;
                r_off  <= io_wbs_adr[PAGE_LSB-1:0];
                r_we   <= io_wbs_we;
                r_wdat <= io_wbs_datwr;
                r_cnt  <= '0;
            end else if (w_active) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_ack_take) begin
                r_rdata <= w_dat_sel;
                r_err   <= 1'b0;
            end
            if (w_err_entry) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        slv_stb_o = '0;
        for (int k = 0; k < NSLV; k++) begin
            slv_stb_o[k] = w_active && (r_sel == 4'(k));
        end
    end

    assign slv_cyc_o    = w_active;
    assign slv_we_o     = w_active && r_we;
    assign slv_adr_o    = w_active ? r_off : '0;
    assign slv_dat_o    = w_active ? r_wdat : '0;
    assign io_wbs_ack   = w_resp && !r_err;
    assign io_wbs_err   = w_resp && r_err;
    assign io_wbs_datrd = io_wbs_ack ? r_rdata : '0;
    assign busy_o       = (r_state != S_IDLE);
    assign err_cnt_o    = r_err_cnt;
    assign o_dbg_state  = r_state;

endmodule
